// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver constants, state encoding and command range
package uart_pkg;

    localparam int DEF_CLK_FREQ = 50000000;
    localparam int DEF_BAUD     = 9600;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        DATA      = ST_DATA,
        STOP      = ST_STOP,
        WAIT_HIGH = ST_WAIT_HIGH
    } rx_state_t;

    localparam logic [7:0] CMD_MIN = 8'h30;
    localparam logic [7:0] CMD_MAX = 8'h36;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b >= CMD_MIN) && (b <= CMD_MAX);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer with async reset to RST_VAL
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver producing command bytes with done/framing strobes
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] info_received,
    output logic       rx_done,
    output logic       frame_error,
    output logic       busy
);

    localparam int CPB_RAW      = CLK_FREQ / BAUD;
    localparam int CLKS_PER_BIT = (CPB_RAW < 4) ? 4 : CPB_RAW;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic w_rx_s;

    rx_state_t        r_state,    w_state_nxt;
    logic [CNT_W-1:0] r_baud_cnt, w_baud_nxt;
    logic [2:0]       r_bit_idx,  w_bit_nxt;
    logic [7:0]       r_shift,    w_shift_nxt;
    logic [7:0]       r_info,     w_info_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_ferr,     w_ferr_nxt;
    logic             r_busy,     w_busy_nxt;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_info     <= '0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_info     <= w_info_nxt;
            r_done     <= w_done_nxt;
            r_ferr     <= w_ferr_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_info_nxt  = r_info;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
        w_busy_nxt  = r_busy;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = START;
                end
            end
            // Resampling mid start bit rejects short low glitches on an idle line.
            START: begin
                if (r_baud_cnt == HALF_CNT) begin
                    if (w_rx_s) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_busy_nxt  = 1'b1;
                        w_baud_nxt  = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = DATA;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_baud_cnt == LAST_CNT) begin
                    w_shift_nxt[r_bit_idx] = w_rx_s;
                    w_baud_nxt             = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_baud_cnt == LAST_CNT) begin
                    w_baud_nxt = '0;
                    if (w_rx_s) begin
                        w_info_nxt  = r_shift;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_HIGH;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + 1'b1;
                end
            end
            // A held-low line (break) must go high before a new start is accepted.
            WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign info_received = r_info;
    assign rx_done       = r_done;
    assign frame_error   = r_ferr;
    assign busy          = r_busy;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx (CLKS_PER_BIT = 16)
module tb_uart_cmd_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] info_received;
    logic       rx_done;
    logic       frame_error;
    logic       busy;

    uart_cmd_rx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .info_received (info_received),
        .rx_done       (rx_done),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int         done_cnt    = 0;
    int         ferr_cnt    = 0;
    int         overlap_cnt = 0;
    int         busy_cyc    = 0;
    int         info_glitch = 0;
    logic [7:0] prev_info   = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            prev_info = info_received;
        end else begin
            if (rx_done) done_cnt++;
            if (frame_error) ferr_cnt++;
            if (rx_done && frame_error) overlap_cnt++;
            if (busy) busy_cyc++;
            if (!rx_done && (info_received !== prev_info)) info_glitch++;
            prev_info = info_received;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        #1 rx = v;
        repeat (n) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_v, CPB);
    endtask

    // Sends one frame and checks strobe counts and the held byte once the line settles.
    task automatic run_frame(input string name, input logic [7:0] data, input logic stop_ok,
                             input int low_hold, input int gap, input logic [7:0] exp_info);
        int d0;
        int f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(data, stop_ok);
        if (!stop_ok) begin
            if (low_hold > 0) hold(1'b0, low_hold);
            #2;
            check({name, "_busy_in_break"}, int'(busy), 1);
            check({name, "_done_in_break"}, done_cnt - d0, 0);
        end
        if (gap > 0) hold(1'b1, gap);
        #2;
        check({name, "_done"}, done_cnt - d0, stop_ok ? 1 : 0);
        check({name, "_ferr"}, ferr_cnt - f0, stop_ok ? 0 : 1);
        check({name, "_info"}, int'(info_received), int'(exp_info));
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       stop_ok;
        int         low_hold;
        int         gap;
        logic [7:0] exp_info;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] model_info;
        int         b0;
        int         d0;
        int         f0;

        vecs[0] = '{"b31",      8'h31, 1'b1,  0, 32, 8'h31};
        vecs[1] = '{"b30_b2b",  8'h30, 1'b1,  0,  0, 8'h30};
        vecs[2] = '{"b36_b2b",  8'h36, 1'b1,  0, 32, 8'h36};
        vecs[3] = '{"b33_break",8'h33, 1'b0, 40, 16, 8'h36};
        vecs[4] = '{"b34",      8'h34, 1'b1,  0, 32, 8'h34};
        vecs[5] = '{"bFF",      8'hFF, 1'b1,  0, 16, 8'hFF};
        vecs[6] = '{"b00",      8'h00, 1'b1,  0, 16, 8'h00};

        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("rst_info", int'(info_received), 0);
        check("rst_done", int'(rx_done), 0);
        check("rst_ferr", int'(frame_error), 0);
        check("rst_busy", int'(busy), 0);
        #1 reset = 1'b0;
        repeat (8) @(posedge clk);

        b0 = busy_cyc;
        d0 = done_cnt;
        f0 = ferr_cnt;
        hold(1'b0, 5);
        hold(1'b1, 40);
        #2;
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy", busy_cyc - b0, 0);
        check("glitch_info", int'(info_received), 0);

        for (int i = 0; i < 7; i++) begin
            b0 = busy_cyc;
            run_frame(vecs[i].name, vecs[i].data, vecs[i].stop_ok, vecs[i].low_hold,
                      vecs[i].gap, vecs[i].exp_info);
            if (i == 0) begin
                check("b31_busy_len_in_range",
                      int'((busy_cyc - b0 >= 140) && (busy_cyc - b0 <= 148)), 1);
            end
        end

        // Abort 0x35 after bit 3 with an asynchronous reset between clock edges.
        d0 = done_cnt;
        f0 = ferr_cnt;
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        #2;
        check("abort_busy_before", int'(busy), 1);
        #1 reset = 1'b1;
        #1;
        check("abort_info", int'(info_received), 0);
        check("abort_done", int'(rx_done), 0);
        check("abort_ferr", int'(frame_error), 0);
        check("abort_busy", int'(busy), 0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4 * CPB) @(posedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_ferr", ferr_cnt - f0, 0);
        run_frame("b32_after_abort", 8'h32, 1'b1, 0, 16, 8'h32);

        model_info = 8'h32;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] data;
            logic       ok;
            int         lh;
            int         gp;
            data = 8'($urandom_range(0, 255));
            ok   = ($urandom_range(0, 4) != 0);
            lh   = ok ? 0 : int'($urandom_range(0, 40));
            gp   = ok ? int'($urandom_range(0, 32)) : int'($urandom_range(4, 32));
            if (ok) model_info = data;
            run_frame($sformatf("rnd%0d", n), data, ok, lh, gp, model_info);
        end

        check("strobe_overlap", overlap_cnt, 0);
        check("info_changed_without_done", info_glitch, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
